// File: rtl/lcd_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : lcd_ctrl_pkg                                           |
// | Description : Shared states, bit positions and command codes for     |
// |               the HD44780 write sequencer.                           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package lcd_ctrl_pkg;

   // Width of the shared timing counter (covers the 1.64 ms clear wait)
   localparam int TIMER_W = 17;

   // Fields of the LCD register word
   localparam int LCD_ON_BIT = 31;
   localparam int BLON_BIT   = 30;
   localparam int RS_BIT     = 8;

   // Commands that need the long execution wait
   localparam logic [7:0] CMD_CLEAR = 8'h01;
   localparam logic [7:0] CMD_HOME  = 8'h02;

   // Sequencer states
   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_SETUP = 3'd1;
   localparam state_t ST_PULSE = 3'd2;
   localparam state_t ST_HOLD  = 3'd3;
   localparam state_t ST_WAIT  = 3'd4;

   // Clear-display and return-home are the only slow instructions
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
      return !rs && ((data == CMD_CLEAR) || (data == CMD_HOME));
   endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : lcd_timer                                              |
// | Description : Loadable down-counter that stops at zero; flags zero.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module lcd_timer #(
   parameter int WIDTH = 17
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   output logic [WIDTH-1:0] o_count,
   output logic             o_zero
);

   logic [WIDTH-1:0] r_count;

   // Load has priority; otherwise count down and park at zero
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (r_count != '0) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_count = r_count;
   assign o_zero  = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/lcd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : lcd_ctrl                                               |
// | Description : Replays captured LCD register writes to an HD44780     |
// |               panel with setup/enable/hold/execution timing.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module lcd_ctrl
   import lcd_ctrl_pkg::*;
#(
   parameter int T_SETUP = 4,
   parameter int T_EN    = 12,
   parameter int T_HOLD  = 2,
   parameter int T_EXEC  = 2000,
   parameter int T_CLEAR = 82000
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [31:0] i_lcd_word,
   input  logic        i_lcd_wr,
   output logic        o_lcd_busy,
   output logic        o_lcd_ovf,
   output logic [7:0]  o_lcd_data,
   output logic        o_lcd_rs,
   output logic        o_lcd_rw,
   output logic        o_lcd_en,
   output logic        o_lcd_on,
   output logic        o_lcd_blon
);

   // Counter reload values: a state of duration D loads D-1
   localparam logic [TIMER_W-1:0] c_ld_setup = TIMER_W'(T_SETUP - 1);
   localparam logic [TIMER_W-1:0] c_ld_en    = TIMER_W'(T_EN - 1);
   localparam logic [TIMER_W-1:0] c_ld_hold  = TIMER_W'(T_HOLD - 1);
   localparam logic [TIMER_W-1:0] c_ld_exec  = TIMER_W'(T_EXEC - 1);
   localparam logic [TIMER_W-1:0] c_ld_clear = TIMER_W'(T_CLEAR - 1);

   state_t             r_state;
   logic               r_pend;
   logic               r_busy;
   logic               r_ovf;
   logic               r_en;
   logic               r_rs;
   logic [7:0]         r_data;
   logic               r_on;
   logic               r_blon;

   logic               w_zero;
   logic               w_load;
   logic [TIMER_W-1:0] w_load_val;
   logic [TIMER_W-1:0] w_cnt;
   logic               w_accept;
   logic               w_unused;

   // A new write is taken when idle, or on the very cycle WAIT expires
   assign w_accept = i_lcd_wr && !r_pend &&
                     ((r_state == ST_IDLE) || ((r_state == ST_WAIT) && w_zero));

   // Bits of the register word this block does not use
   assign w_unused = ^{i_lcd_word[29:9], w_cnt};

   // Counter reload on each state entry
   always_comb begin
      w_load     = 1'b0;
      w_load_val = '0;
      case (r_state)
         ST_IDLE: begin
            w_load     = r_pend;
            w_load_val = c_ld_setup;
         end
         ST_SETUP: begin
            w_load     = w_zero;
            w_load_val = c_ld_en;
         end
         ST_PULSE: begin
            w_load     = w_zero;
            w_load_val = c_ld_hold;
         end
         ST_HOLD: begin
            w_load     = w_zero;
            w_load_val = is_long_cmd(r_rs, r_data) ? c_ld_clear : c_ld_exec;
         end
         default: begin
            w_load     = 1'b0;
            w_load_val = '0;
         end
      endcase
   end

   lcd_timer #(
      .WIDTH (TIMER_W)
   ) u_timer (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .o_count    (w_cnt),
      .o_zero     (w_zero)
   );

   // Sequencer: capture, setup, enable pulse, hold, execution wait
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
         r_pend  <= 1'b0;
         r_busy  <= 1'b0;
         r_ovf   <= 1'b0;
         r_en    <= 1'b0;
         r_rs    <= 1'b0;
         r_data  <= 8'h00;
      end else begin
         r_pend <= w_accept;
         if (i_lcd_wr && !w_accept) begin
            r_ovf <= 1'b1;
         end
         case (r_state)
            ST_IDLE: begin
               if (r_pend) begin
                  r_rs    <= i_lcd_word[RS_BIT];
                  r_data  <= i_lcd_word[7:0];
                  r_busy  <= 1'b1;
                  r_state <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (w_zero) begin
                  r_en    <= 1'b1;
                  r_state <= ST_PULSE;
               end
            end
            ST_PULSE: begin
               if (w_zero) begin
                  r_en    <= 1'b0;
                  r_state <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (w_zero) begin
                  r_state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (w_zero) begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_en    <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Power and backlight follow the register word with one cycle of lag
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_on   <= 1'b0;
         r_blon <= 1'b0;
      end else begin
         r_on   <= i_lcd_word[LCD_ON_BIT];
         r_blon <= i_lcd_word[BLON_BIT];
      end
   end

   assign o_lcd_busy = r_busy;
   assign o_lcd_ovf  = r_ovf;
   assign o_lcd_data = r_data;
   assign o_lcd_rs   = r_rs;
   assign o_lcd_rw   = 1'b0;
   assign o_lcd_en   = r_en;
   assign o_lcd_on   = r_on;
   assign o_lcd_blon = r_blon;

endmodule
`default_nettype wire

// File: tb/tb_lcd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_lcd_ctrl                                            |
// | Description : Directed self-checking bench for lcd_ctrl.             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_lcd_ctrl;

   logic        clk;
   logic        rst;
   logic [31:0] i_lcd_word;
   logic        i_lcd_wr;
   logic        o_lcd_busy;
   logic        o_lcd_ovf;
   logic [7:0]  o_lcd_data;
   logic        o_lcd_rs;
   logic        o_lcd_rw;
   logic        o_lcd_en;
   logic        o_lcd_on;
   logic        o_lcd_blon;

   int n_checks = 0;
   int n_errors = 0;

   lcd_ctrl #(
      .T_SETUP (2),
      .T_EN    (3),
      .T_HOLD  (1),
      .T_EXEC  (5),
      .T_CLEAR (20)
   ) dut (
      .i_clk      (clk),
      .i_reset    (rst),
      .i_lcd_word (i_lcd_word),
      .i_lcd_wr   (i_lcd_wr),
      .o_lcd_busy (o_lcd_busy),
      .o_lcd_ovf  (o_lcd_ovf),
      .o_lcd_data (o_lcd_data),
      .o_lcd_rs   (o_lcd_rs),
      .o_lcd_rw   (o_lcd_rw),
      .o_lcd_en   (o_lcd_en),
      .o_lcd_on   (o_lcd_on),
      .o_lcd_blon (o_lcd_blon)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // One-cycle write strobe; returns just after the strobe edge
   task automatic strobe(input logic [31:0] w);
      i_lcd_word = w;
      i_lcd_wr   = 1'b1;
      tick();
      i_lcd_wr   = 1'b0;
   endtask

   // Follow a transfer from its strobe edge until busy drops (bounded)
   task automatic measure(input string tag, input logic [7:0] exp_data, input logic exp_rs,
                          input int exp_busy);
      int en_first;
      int en_cnt;
      int busy_cnt;
      int bad;
      en_first = -1;
      en_cnt   = 0;
      busy_cnt = 0;
      bad      = 0;
      for (int k = 1; k <= 100; k++) begin
         tick();
         if (o_lcd_en) begin
            en_cnt++;
            if (en_first < 0) en_first = k;
         end
         if (o_lcd_busy) begin
            busy_cnt++;
            if ((o_lcd_data != exp_data) || (o_lcd_rs != exp_rs) || o_lcd_rw) bad++;
         end
         if (!o_lcd_busy && k > 1) break;
      end
      check({tag, "_en_start"}, en_first, 3);
      check({tag, "_en_len"}, en_cnt, 3);
      check({tag, "_busy_len"}, busy_cnt, exp_busy);
      check({tag, "_pins_stable"}, bad, 0);
   endtask

   task automatic wait_idle(input string tag);
      for (int k = 0; k < 100 && o_lcd_busy; k++) tick();
      check({tag, "_idle"}, o_lcd_busy, 0);
   endtask

   initial begin
      rst        = 1'b1;
      i_lcd_wr   = 1'b0;
      i_lcd_word = 32'h0;
      #12;
      // Reset values
      check("rst_outs", {o_lcd_busy, o_lcd_ovf, o_lcd_data, o_lcd_rs, o_lcd_rw,
                         o_lcd_en, o_lcd_on, o_lcd_blon}, 0);
      tick();
      #3 rst = 1'b0;
      begin
         int en_seen;
         int busy_seen;
         en_seen   = 0;
         busy_seen = 0;
         for (int k = 0; k < 5; k++) begin
            tick();
            en_seen   += int'(o_lcd_en);
            busy_seen += int'(o_lcd_busy);
         end
         check("post_rst_en", en_seen, 0);
         check("post_rst_busy", busy_seen, 0);
      end

      // Data write 0x41
      strobe(32'h8000_0141);
      check("data_busy_at_N", o_lcd_busy, 0);
      tick();
      check("data_N1_data", o_lcd_data, 8'h41);
      check("data_N1_rs", o_lcd_rs, 1);
      check("data_N1_busy", o_lcd_busy, 1);
      check("data_N1_en", o_lcd_en, 0);
      check("data_on", o_lcd_on, 1);
      // measure restarts from edge N+1, so shift: finish via generic loop
      wait_idle("data_first");

      // Full timing measurement of an ordinary data write
      strobe(32'h0000_0141);
      measure("wr41", 8'h41, 1'b1, 11);

      // Clear display: long wait
      strobe(32'h0000_0001);
      tick();
      check("clr_rs", o_lcd_rs, 0);
      check("clr_data", o_lcd_data, 8'h01);
      wait_idle("clr_first");
      strobe(32'h0000_0001);
      measure("clr", 8'h01, 1'b0, 26);

      // Return home also uses the long wait
      strobe(32'h0000_0002);
      measure("home", 8'h02, 1'b0, 26);

      // Command 0x03 is an ordinary command
      strobe(32'h0000_0003);
      measure("cmd03", 8'h03, 1'b0, 11);

      // Strobe on the edge where WAIT ends is accepted
      strobe(32'h0000_0155);
      for (int k = 0; k < 11; k++) tick();
      strobe(32'h0000_0177);
      check("edge_busy_fell", o_lcd_busy, 0);
      measure("edge", 8'h77, 1'b1, 11);
      check("edge_ovf", o_lcd_ovf, 0);

      // Strobe while busy is dropped and flagged
      strobe(32'h0000_0155);
      for (int k = 0; k < 3; k++) tick();
      strobe(32'h0000_0166);
      check("ovf_set", o_lcd_ovf, 1);
      check("ovf_data_kept", o_lcd_data, 8'h55);
      wait_idle("ovf");
      check("ovf_data_after", o_lcd_data, 8'h55);
      check("ovf_sticky", o_lcd_ovf, 1);

      // Power/backlight follow the word without a strobe
      i_lcd_word = 32'hC000_0000;
      check("on_lag", {o_lcd_on, o_lcd_blon}, 2'b00);
      begin
         int en_seen;
         en_seen = 0;
         tick();
         check("on_blon", {o_lcd_on, o_lcd_blon}, 2'b11);
         for (int k = 0; k < 6; k++) begin
            tick();
            en_seen += int'(o_lcd_en);
         end
         check("on_no_en", en_seen, 0);
         check("on_no_busy", o_lcd_busy, 0);
      end

      // Reset in the middle of the enable pulse
      strobe(32'h0000_0142);
      for (int k = 0; k < 3; k++) tick();
      check("rst_pulse_en_hi", o_lcd_en, 1);
      #2 rst = 1'b1;
      #1;
      check("rst_async_en", o_lcd_en, 0);
      tick();
      #3 rst = 1'b0;
      check("rst_busy", o_lcd_busy, 0);
      check("rst_ovf", o_lcd_ovf, 0);
      begin
         int en_seen;
         int busy_seen;
         en_seen   = 0;
         busy_seen = 0;
         for (int k = 0; k < 8; k++) begin
            tick();
            en_seen   += int'(o_lcd_en);
            busy_seen += int'(o_lcd_busy);
         end
         check("rst_after_en", en_seen, 0);
         check("rst_after_busy", busy_seen, 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
